// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file write path.
// Widths, the hard-wired zero register and arbiter states.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic {
    PRI_A,
    FORCE_B
  } arb_state_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive cycles requester B was blocked.
// Flags the cycle whose increment reaches the limit.
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clock,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit,
  output logic o_hit
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] r_count;

  // Clear wins over increment; hold once saturated.
  always_ff @(posedge clock) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIM)) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign o_at_limit = (r_count == LIM);
  assign o_hit      = i_inc && (r_count >= (LIM - 4'd1));

endmodule

// File: rtl/regwrite_arbiter.sv
// Two-requester arbiter for the single register file write port.
// A has priority; B is forced through after a bounded wait.
module regwrite_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W       = regfile_pkg::DATA_W,
  parameter int ADDR_W       = regfile_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              regWrite,
  output logic [ADDR_W-1:0] wreg,
  output logic [DATA_W-1:0] wdata,
  output logic              forced
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic              r_we;
  logic [ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0] r_wdata;

  logic w_a_acc;
  logic w_b_acc;
  logic w_b_block;
  logic w_clr;
  logic w_hit;
  logic w_at_limit;

  assign w_a_acc = a_valid && a_ready;
  assign w_b_acc = b_valid && b_ready;

  // Blocked cycles derive from state, not b_ready, to keep paths short.
  assign w_b_block = b_valid && a_valid && (r_state == PRI_A);
  assign w_clr     = w_b_acc || !b_valid;

  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clock     (clock),
    .i_rst     (reset),
    .i_clr     (w_clr),
    .i_inc     (w_b_block),
    .o_at_limit(w_at_limit),
    .o_hit     (w_hit)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= PRI_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and ready/forced decode; readies are held low in reset.
  always_comb begin
    w_state_nxt = r_state;
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    forced      = 1'b0;
    unique case (r_state)
      PRI_A: begin
        a_ready = !reset;
        b_ready = !reset && !a_valid;
        if (w_hit || w_at_limit) begin
          w_state_nxt = FORCE_B;
        end
      end
      FORCE_B: begin
        b_ready     = !reset;
        forced      = 1'b1;
        // B is granted this cycle or has withdrawn: one slot only.
        w_state_nxt = PRI_A;
      end
      default: begin
        w_state_nxt = PRI_A;
      end
    endcase
  end

  // Output register captures the winner; $zero never gets an enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else if (w_a_acc) begin
      r_we    <= (a_addr != ZERO);
      r_wreg  <= a_addr;
      r_wdata <= a_data;
    end else if (w_b_acc) begin
      r_we    <= (b_addr != ZERO);
      r_wreg  <= b_addr;
      r_wdata <= b_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  // A pending write is squashed while reset is high.
  assign regWrite = r_we && !reset;
  assign wreg     = r_wreg;
  assign wdata    = r_wdata;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed and random checks of regwrite_arbiter
// against a cycle-level model of the arbitration rules.
module tb_regwrite_arbiter;

  localparam int LIM = 4;

  logic        clock;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        regWrite;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        forced;

  regwrite_arbiter #(
    .DATA_W      (32),
    .ADDR_W      (5),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .regWrite(regWrite),
    .wreg    (wreg),
    .wdata   (wdata),
    .forced  (forced)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file fed by the DUT write port.
  logic [31:0] tb_rf [32] = '{default: 32'd0};
  always @(posedge clock) begin
    if (regWrite === 1'b1) tb_rf[wreg] <= wdata;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [31:0] gold [32];
  int          waited;
  bit          known;
  bit          exp_we;
  logic [4:0]  exp_wreg;
  logic [31:0] exp_wdata;

  bit          a_acc_dut, b_acc_dut;
  bit          a_pend, b_pend;
  logic [4:0]  pa_addr, pb_addr;
  logic [31:0] pa_data, pb_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at negedge with inputs already driven.
  task automatic cycle();
    bit fb, ar, br, aa, ba;
    #1;
    if (a_pend) begin
      chk("a_hold_valid", a_valid, 1);
      chk("a_hold_addr", a_addr, pa_addr);
      chk("a_hold_data", a_data, pa_data);
    end
    if (b_pend) begin
      chk("b_hold_valid", b_valid, 1);
      chk("b_hold_addr", b_addr, pb_addr);
      chk("b_hold_data", b_data, pb_data);
    end
    fb = known && (waited >= LIM);
    ar = !reset && !fb;
    br = !reset && (fb || !a_valid);
    chk("a_ready", a_ready, ar);
    chk("b_ready", b_ready, br);
    if (known) chk("forced", forced, fb);
    chk("regWrite_pre", regWrite, exp_we && !reset);
    aa = a_valid && ar;
    ba = b_valid && br;
    a_acc_dut = a_valid && a_ready;
    b_acc_dut = b_valid && b_ready;
    a_pend = a_valid && !a_acc_dut;
    b_pend = b_valid && !b_acc_dut;
    pa_addr = a_addr; pa_data = a_data;
    pb_addr = b_addr; pb_data = b_data;
    @(posedge clock);
    #1;
    if (exp_we && !reset) gold[exp_wreg] = exp_wdata;
    if (reset) begin
      known = 1; waited = 0;
      exp_we = 0; exp_wreg = 0; exp_wdata = 0;
    end else begin
      if (b_valid && !br) waited = (waited < LIM) ? waited + 1 : LIM;
      else waited = 0;
      if (aa) begin
        exp_we = (a_addr != 0); exp_wreg = a_addr; exp_wdata = a_data;
      end else if (ba) begin
        exp_we = (b_addr != 0); exp_wreg = b_addr; exp_wdata = b_data;
      end else begin
        exp_we = 0;
      end
    end
    chk("regWrite", regWrite, exp_we && !reset);
    if (known) begin
      chk("wreg", wreg, exp_wreg);
      chk("wdata", wdata, exp_wdata);
    end
    @(negedge clock);
  endtask

  // A streams continuously while B waits on a fixed write.
  task automatic starve_run();
    int  nwait;
    bit  got, f_at;
    a_valid = 1; a_addr = 5'd1; a_data = $urandom;
    b_valid = 1; b_addr = 5'd3; b_data = 32'hB0B0_0003;
    nwait = 0; got = 0; f_at = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      f_at = forced;
      cycle();
      if (b_acc_dut) got = 1;
      else nwait++;
      if (a_acc_dut) begin
        a_addr = a_addr + 5'd1; a_data = $urandom;
      end
    end
    b_valid = 0;
    chk("b_wait", nwait, LIM);
    chk("b_granted", got, 1);
    chk("forced_at_grant", f_at, 1);
    cycle();
    chk("a_resume", a_acc_dut, 1);
    a_valid = 0;
    cycle();
  endtask

  task automatic drive_rand();
    if (!a_pend) begin
      a_valid = ($urandom_range(0, 3) != 0);
      a_addr  = 5'($urandom_range(0, 31));
      a_data  = $urandom;
    end
    if (!b_pend) begin
      b_valid = ($urandom_range(0, 1) != 0);
      b_addr  = 5'($urandom_range(0, 31));
      b_data  = $urandom;
    end
    reset = ($urandom_range(0, 79) == 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gold[i] = 32'd0;
    waited = 0; known = 0;
    exp_we = 0; exp_wreg = 0; exp_wdata = 0;
    a_pend = 0; b_pend = 0;
    reset = 1; a_valid = 0; b_valid = 0;
    a_addr = 0; a_data = 0; b_addr = 0; b_data = 0;
    @(negedge clock);

    cycle();
    cycle();
    reset = 0;
    cycle();
    chk("idle_wreg", wreg, 0);

    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    cycle();
    chk("wdata_deadbeef", wdata, 32'hDEADBEEF);
    a_valid = 0;
    cycle();
    chk("rf5", tb_rf[5], 32'hDEADBEEF);

    starve_run();

    b_valid = 1; b_addr = 5'd0; b_data = 32'h1234;
    cycle();
    chk("b_zero_accept", b_acc_dut, 1);
    b_valid = 0;
    cycle();
    cycle();
    chk("rf0", tb_rf[0], 0);

    a_valid = 1; a_addr = 5'd7; a_data = 32'h11;
    b_valid = 1; b_addr = 5'd7; b_data = 32'h22;
    cycle();
    chk("same_addr_a_first", a_acc_dut, 1);
    a_valid = 0;
    cycle();
    chk("rf7_a", tb_rf[7], 32'h11);
    b_valid = 0;
    cycle();
    chk("rf7_b", tb_rf[7], 32'h22);

    a_valid = 1; a_addr = 5'd9; a_data = 32'h99;
    cycle();
    a_valid = 0; reset = 1;
    cycle();
    reset = 0;
    cycle();
    cycle();
    chk("rf9_dropped", tb_rf[9], 0);
    chk("forced_after_rst", forced, 0);
    starve_run();

    for (int n = 0; n < 400; n++) begin
      drive_rand();
      cycle();
    end

    reset = 0; a_valid = 0; b_valid = 0;
    a_pend = 0; b_pend = 0;
    for (int n = 0; n < 3; n++) cycle();
    for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), tb_rf[i], gold[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regwrite_arbiter.md
# regwrite_arbiter

Write-port arbiter for the 32×32 register file. The register file has one write port (`regWrite`/`wreg`/`wdata`), and two producers compete for it. Requester A is the main writeback path. Requester B is the multi-cycle unit (mul/div, load return). The block grants one requester per cycle with fixed A-over-B priority plus a starvation guard, registers the winning write, and drives the register file write port directly.

## Interface
Parameters:
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width
- `STARVE_LIMIT`, 4, consecutive B-blocked cycles before B is forced through; legal range 1..15

Ports:
- `clock`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `a_valid`  in  1  A has a write pending
- `a_ready`  out  1  A write accepted this cycle when `a_valid && a_ready`
- `a_addr`  in  ADDR_W  A destination register
- `a_data`  in  DATA_W  A write data
- `b_valid`  in  1  B has a write pending
- `b_ready`  out  1  B write accepted this cycle when `b_valid && b_ready`
- `b_addr`  in  ADDR_W  B destination register
- `b_data`  in  DATA_W  B write data
- `regWrite`  out  1  register file write enable (registered)
- `wreg`  out  ADDR_W  register file write address (registered)
- `wdata`  out  DATA_W  register file write data (registered)
- `forced`  out  1  high while the arbiter is in FORCE_B

## Operation
- FSM states:
  - PRI_A (reset state): `a_ready` = 1; `b_ready` = !`a_valid`.
  - FORCE_B: `a_ready` = 0; `b_ready` = 1; `forced` = 1.
- Starvation counter `starve` (4 bit):
  - +1 on every cycle with `b_valid && !b_ready`, saturating at `STARVE_LIMIT`.
  - Cleared on any B accept.
  - Cleared when `b_valid` drops.
- Transitions:
  - PRI_A→FORCE_B at the edge where `starve` would reach `STARVE_LIMIT`.
  - FORCE_B→PRI_A at the edge of the B accept.
  - FORCE_B→PRI_A also when `b_valid` drops while in FORCE_B (no grant is made).
- Accept (exactly one requester per cycle):
  - Output register loads the winner's addr/data.
  - `regWrite` is set next cycle.
  - No accept in a cycle → `regWrite` = 0 next cycle; `wreg`/`wdata` hold their last values.
- Writes to register 0:
  - The handshake completes normally.
  - `regWrite` stays 0 for that slot, so $zero is never written.
- Same address on A and B in the same cycle: no merging. The loser retries, so the later-granted write wins in the register file.
- Ready outputs depend only on state and `a_valid`, never on `b_valid`. There is no combinational path from B inputs to `a_ready`.
- During `reset` high: `a_ready` = `b_ready` = 0, and no accept occurs.

## Timing
- Latency: accept in cycle N → `regWrite`/`wreg`/`wdata` valid in cycle N+1 → register file updated at the N+1→N+2 edge.
- Throughput: one write per cycle, sustained.
- Worst-case B wait under continuous A traffic: `STARVE_LIMIT` blocked cycles, then grant on the next cycle.
- Reset values:
  - `regWrite` = 0, `wreg` = 0, `wdata` = 0, `forced` = 0.
  - State = PRI_A, `starve` = 0.
- Reset asserted mid-operation: a write already in the output register is dropped, and `regWrite` = 0 on the cycle after reset is sampled.
- Requesters must hold addr/data stable while valid is high and unaccepted. This is checked by a bench assertion, not by the RTL.

## Structure
- Shared package `regfile_pkg`:
  - `DATA_W`, `ADDR_W`
  - `ZERO_REG` = 5'd0
  - arbiter state enum {PRI_A, FORCE_B}
- One natural sub-module, `starve_counter`: saturating counter with clear, increment, and `at_limit` flag, parameterised by `STARVE_LIMIT`.
- The output register and FSM stay in the top module.

## Test plan
- Reset, then idle → all outputs 0; `a_ready` = 1, `b_ready` = 1 from the first post-reset cycle.
- A alone writes addr 5 = 0xDEADBEEF → `regWrite` = 1, `wreg` = 5, `wdata` = 0xDEADBEEF exactly one cycle after accept; `regWrite` = 0 the cycle after.
- A and B both valid, `STARVE_LIMIT` = 4, A continuous → B blocked 4 cycles, `forced` = 1 in cycle 5, B granted, then A resumes; no cycle with two accepts.
- B writes addr 0 = 0x1234 → `b_ready` handshake completes; `regWrite` stays 0; register 0 reads 0.
- A and B simultaneously target addr 7 (A = 0x11, B = 0x22) → A lands first; B is forced or granted later; final register 7 = 0x22.
- Reset asserted the cycle after an accept to addr 9 → no write reaches the register file; state returns to PRI_A and `starve` = 0.
